// File: rtl/alu_seq.sv
// alu_seq: registered execute-stage ALU with CCR flags, stall/flush and an
// optional iterative shift-add multiplier enabled by defining ALU_MUL_EN.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | accepting ops; single-cycle ops commit at the accepting edge
// ST_MUL_BUSY | shift-add iterations, counter counts WIDTH down to terminal 1
// ST_MUL_DONE | one cycle to commit the product to result/CCR
module alu_seq #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       func,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic             stall,
   input  logic             flush,
   input  logic             flags_wr,
   input  logic [3:0]       flags_in,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       out_flags
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL_BUSY = 2'd1,
      ST_MUL_DONE = 2'd2
   } state_t;

   localparam logic [3:0] F_SETC = 4'h1, F_CLRC = 4'h2, F_MOV1 = 4'h3, F_MOV2 = 4'h4;
   localparam logic [3:0] F_NOT  = 4'h5, F_INC  = 4'h6, F_DEC  = 4'h7, F_ADD  = 4'h8;
   localparam logic [3:0] F_SUB  = 4'h9, F_AND  = 4'ha, F_OR   = 4'hb, F_SHL  = 4'hc;
   localparam logic [3:0] F_SHR  = 4'hd, F_MUL  = 4'he;
   localparam int FZ = 0, FN = 1, FC = 2, FV = 3;
   localparam int MSB = WIDTH - 1;
   localparam logic [SHAMT_W:0] WIDTH_S = (SHAMT_W+1)'(WIDTH);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               out_valid_q, out_valid_d;
   logic [3:0]         flags_q, flags_d;
   logic               accept;
   logic [WIDTH-1:0]   alu_res;
   logic [3:0]         alu_flags;
   logic               upd_zn;
   logic [WIDTH-1:0]   add_b;
   logic               add_sub;
   logic [WIDTH:0]     add_sum;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH:0]     shl_ext;
   logic [WIDTH:0]     shr_ext;

`ifdef ALU_MUL_EN
   localparam int CNT_W = $clog2(WIDTH + 1);
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   assign in_ready = (state_q == ST_IDLE) & ~stall & ~rst;
`else
   assign in_ready = ~stall & ~rst;
`endif

   assign accept    = in_valid & in_ready & ~flush;
   assign result    = result_q;
   assign out_valid = out_valid_q;
   assign out_flags = flags_q;

   // Extra guard bit catches the last bit shifted out in either direction.
   assign shamt   = op2[SHAMT_W-1:0];
   assign shl_ext = {1'b0, op1} << shamt;
   assign shr_ext = {op1, 1'b0} >> shamt;

   // Shared WIDTH+1 adder for ADD/SUB/INC/DEC; top bit is carry or borrow.
   always_comb begin
      add_b   = op2;
      add_sub = 1'b0;
      case (func)
         F_INC: add_b = WIDTH'(1);
         F_DEC: begin
            add_b   = WIDTH'(1);
            add_sub = 1'b1;
         end
         F_SUB: add_sub = 1'b1;
         default: ;
      endcase
      add_sum = add_sub ? ({1'b0, op1} - {1'b0, add_b}) : ({1'b0, op1} + {1'b0, add_b});
   end

   // Single-cycle result and the flags it would commit.
   always_comb begin
      alu_res   = '0;
      alu_flags = flags_q;
      upd_zn    = 1'b0;
      case (func)
         F_SETC: alu_flags[FC] = 1'b1;
         F_CLRC: alu_flags[FC] = 1'b0;
         F_MOV1: alu_res = op1;
         F_MOV2: alu_res = op2;
         F_NOT: begin
            alu_res = ~op1;
            upd_zn  = 1'b1;
         end
         F_INC, F_DEC, F_ADD, F_SUB: begin
            alu_res       = add_sum[WIDTH-1:0];
            alu_flags[FC] = add_sum[WIDTH];
            alu_flags[FV] = add_sub ? ((op1[MSB] != add_b[MSB]) & (add_sum[MSB] != op1[MSB]))
                                    : ((op1[MSB] == add_b[MSB]) & (add_sum[MSB] != op1[MSB]));
            upd_zn        = 1'b1;
         end
         F_AND: begin
            alu_res = op1 & op2;
            upd_zn  = 1'b1;
         end
         F_OR: begin
            alu_res = op1 | op2;
            upd_zn  = 1'b1;
         end
         F_SHL, F_SHR: begin
            upd_zn = 1'b1;
            if (shamt == '0) begin
               alu_res = op1;
            end else if ({1'b0, shamt} >= WIDTH_S) begin
               alu_res       = '0;
               alu_flags[FC] = 1'b0;
            end else if (func == F_SHL) begin
               alu_res       = shl_ext[WIDTH-1:0];
               alu_flags[FC] = shl_ext[WIDTH];
            end else begin
               alu_res       = shr_ext[WIDTH:1];
               alu_flags[FC] = shr_ext[0];
            end
         end
         default: ;
      endcase
      if (upd_zn) begin
         alu_flags[FZ] = ~|alu_res;
         alu_flags[FN] = alu_res[MSB];
      end
   end

   // Next state: flush beats stall; a flags restore overrides any ALU flag update.
   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      out_valid_d = out_valid_q;
      flags_d     = flags_q;
`ifdef ALU_MUL_EN
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      cnt_d       = cnt_q;
`endif
      if (flush) begin
         out_valid_d = 1'b0;
         state_d     = ST_IDLE;
`ifdef ALU_MUL_EN
         cnt_d       = '0;
`endif
      end else if (!stall) begin
         out_valid_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
`ifdef ALU_MUL_EN
                  if (func == F_MUL) begin
                     acc_d    = '0;
                     mcand_d  = {{WIDTH{1'b0}}, op1};
                     mplier_d = op2;
                     cnt_d    = CNT_W'(WIDTH);
                     state_d  = ST_MUL_BUSY;
                  end else
`endif
                  begin
                     result_d    = alu_res;
                     flags_d     = alu_flags;
                     out_valid_d = 1'b1;
                  end
               end
            end
`ifdef ALU_MUL_EN
            ST_MUL_BUSY: begin
               if (mplier_q[0]) acc_d = acc_q + mcand_q;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = ST_MUL_DONE;
            end
            ST_MUL_DONE: begin
               result_d    = acc_q[WIDTH-1:0];
               flags_d[FZ] = ~|acc_q[WIDTH-1:0];
               flags_d[FN] = acc_q[MSB];
               flags_d[FC] = |acc_q[2*WIDTH-1:WIDTH];
               out_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end
      if (flags_wr) flags_d = flags_in;
   end

   // All state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         flags_q     <= '0;
`ifdef ALU_MUL_EN
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         flags_q     <= flags_d;
`ifdef ALU_MUL_EN
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         cnt_q       <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=16, SHAMT_W=5 so shift amounts >= WIDTH are reachable).
// MUL sections are active when ALU_MUL_EN is defined.
module tb_alu_seq;
   localparam int W  = 16;
   localparam int SH = 5;
`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, in_valid, stall, flush, flags_wr;
   logic [3:0]    func, flags_in;
   logic [W-1:0]  op1, op2;
   logic          in_ready, out_valid;
   logic [W-1:0]  result;
   logic [3:0]    out_flags;

   int checks   = 0;
   int failures = 0;

   alu_seq #(.WIDTH(W), .SHAMT_W(SH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .func(func), .op1(op1), .op2(op2), .stall(stall), .flush(flush),
      .flags_wr(flags_wr), .flags_in(flags_in), .out_valid(out_valid),
      .result(result), .out_flags(out_flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint sgn(input longint x);
      return (x >= (longint'(1) << (W-1))) ? x - (longint'(1) << W) : x;
   endfunction

   // Reference ALU in plain integer arithmetic.
   function automatic void alu_model(input logic [3:0] f, input longint a, input longint b,
                                     input logic [3:0] fi, output longint r, output logic [3:0] fo);
      longint m, h, bb, raw, sr, s;
      bit zn;
      m = longint'(1) << W;
      h = m >> 1;
      r = 0; fo = fi; zn = 1'b0;
      case (f)
         4'd1: fo[2] = 1'b1;
         4'd2: fo[2] = 1'b0;
         4'd3: r = a;
         4'd4: r = b;
         4'd5: begin r = m - 1 - a; zn = 1'b1; end
         4'd6, 4'd7, 4'd8, 4'd9: begin
            bb = (f == 4'd6 || f == 4'd7) ? 1 : b;
            if (f == 4'd7 || f == 4'd9) begin
               raw = a - bb; fo[2] = (a < bb); sr = sgn(a) - sgn(bb);
            end else begin
               raw = a + bb; fo[2] = (raw >= m); sr = sgn(a) + sgn(bb);
            end
            r = (raw + m) % m;
            fo[3] = (sr >= h) || (sr < -h);
            zn = 1'b1;
         end
         4'd10: begin r = a & b; zn = 1'b1; end
         4'd11: begin r = a | b; zn = 1'b1; end
         4'd12, 4'd13: begin
            s = b % (longint'(1) << SH);
            zn = 1'b1;
            if (s == 0) r = a;
            else if (s >= W) begin r = 0; fo[2] = 1'b0; end
            else if (f == 4'd12) begin r = (a << s) % m; fo[2] = ((a >> (W - s)) & 1) != 0; end
            else begin r = a >> s; fo[2] = ((a >> (s - 1)) & 1) != 0; end
         end
         default: r = 0;
      endcase
      if (zn) begin fo[0] = (r == 0); fo[1] = (r >= h); end
   endfunction

   longint     m_res, m_prod, r_tmp;
   logic [3:0] m_flg, f_tmp;
   logic       m_val;
   int         m_busy = 0;
   bit         m_started = 1'b0;

   // Cycle model: what the outputs must be after each edge.
   always @(posedge clk) begin
      m_started = 1'b1;
      if (rst) begin
         m_res = 0; m_val = 1'b0; m_flg = 4'h0; m_busy = 0;
      end else begin
         if (flush) begin
            m_val = 1'b0; m_busy = 0;
         end else if (!stall) begin
            m_val = 1'b0;
            if (m_busy > 0) begin
               m_busy--;
               if (m_busy == 0) begin
                  m_res = m_prod % (longint'(1) << W);
                  m_flg[0] = (m_res == 0);
                  m_flg[1] = (m_res >= (longint'(1) << (W-1)));
                  m_flg[2] = (m_prod >> W) != 0;
                  m_val = 1'b1;
               end
            end else if (in_valid) begin
               if (MUL_EN && func == 4'he) begin
                  m_busy = W + 1;
                  m_prod = longint'(op1) * longint'(op2);
               end else begin
                  alu_model(func, longint'(op1), longint'(op2), m_flg, r_tmp, f_tmp);
                  m_res = r_tmp; m_flg = f_tmp; m_val = 1'b1;
               end
            end
         end
         if (flags_wr) m_flg = flags_in;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_started) begin
         chk("cyc_result", 32'(result), 32'(m_res[W-1:0]));
         chk("cyc_valid", 32'(out_valid), 32'(m_val));
         chk("cyc_flags", 32'(out_flags), 32'(m_flg));
         chk("cyc_ready", 32'(in_ready), 32'((m_busy == 0) && !stall && !rst));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic op(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      in_valid = 1'b1; func = f; op1 = a; op2 = b;
   endtask

   initial begin
      int waited;
      rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; flags_wr = 1'b0;
      func = 4'h0; flags_in = 4'h0; op1 = '0; op2 = '0;
      tick(); tick();
      chk("rst_result", 32'(result), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_flags", 32'(out_flags), 32'h0);
      rst = 1'b0;

      op(4'h8, 16'h7fff, 16'h0001); tick();
      chk("add_ovf_res", 32'(result), 32'h8000);
      chk("add_ovf_flags", 32'(out_flags), 32'b1010);
      chk("add_ovf_valid", 32'(out_valid), 32'h1);
      in_valid = 1'b0; tick();
      chk("valid_drop", 32'(out_valid), 32'h0);
      chk("result_hold", 32'(result), 32'h8000);

      op(4'h9, 16'h0001, 16'h0002); tick();
      chk("sub_res", 32'(result), 32'hffff);
      chk("sub_flags", 32'(out_flags), 32'b0110);
      op(4'h4, 16'h0000, 16'h1234); tick();
      chk("mov2_res", 32'(result), 32'h1234);
      chk("mov2_flags", 32'(out_flags), 32'b0110);

      op(4'hc, 16'h8001, 16'd1); tick();
      chk("shl1_res", 32'(result), 32'h0002);
      chk("shl1_flags", 32'(out_flags), 32'b0100);
      op(4'hd, 16'h0003, 16'd0); tick();
      chk("shr0_res", 32'(result), 32'h0003);
      chk("shr0_flags", 32'(out_flags), 32'b0100);
      op(4'hc, 16'h8001, 16'd16); tick();
      chk("shl16_res", 32'(result), 32'h0000);
      chk("shl16_flags", 32'(out_flags), 32'b0001);
      op(4'hd, 16'hffff, 16'd20); tick();
      chk("shr20_res", 32'(result), 32'h0000);

      flags_wr = 1'b1; flags_in = 4'b1010;
      op(4'h8, 16'h0001, 16'h0001); tick();
      flags_wr = 1'b0;
      chk("fwr_res", 32'(result), 32'h0002);
      chk("fwr_flags", 32'(out_flags), 32'b1010);

      op(4'h1, 16'h0000, 16'h0000); tick();
      chk("setc_flags", 32'(out_flags), 32'b1110);
      chk("setc_res", 32'(result), 32'h0);
      op(4'h2, 16'h0000, 16'h0000); tick();
      chk("clrc_flags", 32'(out_flags), 32'b1010);

      op(4'h6, 16'hffff, 16'h0000); tick();
      chk("inc_wrap_res", 32'(result), 32'h0000);
      chk("inc_wrap_flags", 32'(out_flags), 32'b0101);
      op(4'h7, 16'h8000, 16'h0000); tick();
      chk("dec_ovf_res", 32'(result), 32'h7fff);
      chk("dec_ovf_flags", 32'(out_flags), 32'b1000);
      op(4'h7, 16'h0000, 16'h0000); tick();
      chk("dec_borrow_flags", 32'(out_flags), 32'b0110);

      op(4'ha, 16'hf0f0, 16'h0f0f); tick();
      chk("and_flags", 32'(out_flags), 32'b0101);
      op(4'hb, 16'h8000, 16'h0001); tick();
      chk("or_res", 32'(result), 32'h8001);
      chk("or_flags", 32'(out_flags), 32'b0110);
      op(4'h5, 16'hffff, 16'h0000); tick();
      chk("not_flags", 32'(out_flags), 32'b0101);
      op(4'h0, 16'h1111, 16'h2222); tick();
      chk("nop_res", 32'(result), 32'h0);
      chk("nop_valid", 32'(out_valid), 32'h1);
      op(4'hf, 16'h1111, 16'h2222); tick();
      chk("rsvd_flags", 32'(out_flags), 32'b0101);
      if (!MUL_EN) begin
         op(4'he, 16'h0003, 16'h0005); tick();
         chk("mul_off_res", 32'(result), 32'h0);
         chk("mul_off_valid", 32'(out_valid), 32'h1);
         chk("mul_off_flags", 32'(out_flags), 32'b0101);
      end

      for (int i = 0; i < 24; i++) begin
         op(4'($urandom_range(0, 13)), 16'($urandom), 16'($urandom));
         flags_wr = ($urandom_range(0, 7) == 0);
         flags_in = 4'($urandom);
         stall    = ($urandom_range(0, 5) == 0);
         tick();
      end
      flags_wr = 1'b0; stall = 1'b0;

      op(4'h8, 16'h0002, 16'h0003); tick();
      chk("stall_pre_res", 32'(result), 32'h5);
      stall = 1'b1;
      op(4'h8, 16'h0009, 16'h0009);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_res", 32'(result), 32'h5);
         chk("stall_valid", 32'(out_valid), 32'h1);
      end
      flags_wr = 1'b1; flags_in = 4'b1111; tick();
      flags_wr = 1'b0;
      chk("stall_fwr_flags", 32'(out_flags), 32'b1111);
      chk("stall_fwr_valid", 32'(out_valid), 32'h1);
      rst = 1'b1; tick();
      chk("stall_rst_res", 32'(result), 32'h0);
      chk("stall_rst_valid", 32'(out_valid), 32'h0);
      chk("stall_rst_flags", 32'(out_flags), 32'h0);
      rst = 1'b0; stall = 1'b0;

      op(4'h9, 16'h0001, 16'h0002); tick();
      flush = 1'b1;
      op(4'h8, 16'h0001, 16'h0001); tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", 32'(out_valid), 32'h0);
      chk("flush_res", 32'(result), 32'hffff);
      chk("flush_flags", 32'(out_flags), 32'b0110);

      if (MUL_EN) begin
         op(4'he, 16'h0100, 16'h0100); tick();
         in_valid = 1'b0;
         for (int i = 0; i <= W; i++) begin
            chk("mul_busy_ready", 32'(in_ready), 32'h0);
            chk("mul_busy_valid", 32'(out_valid), 32'h0);
            tick();
         end
         chk("mul_done_valid", 32'(out_valid), 32'h1);
         chk("mul_done_res", 32'(result), 32'h0);
         chk("mul_done_zc", 32'(out_flags[2:0]), 32'b101);
         chk("mul_done_ready", 32'(in_ready), 32'h1);

         op(4'he, 16'h1234, 16'h0003); tick();
         in_valid = 1'b0;
         tick(); tick(); tick();
         stall = 1'b1; tick(); tick();
         stall = 1'b0;
         waited = 0;
         while (!out_valid && waited < 40) begin
            tick();
            waited++;
         end
         chk("mul2_seen", 32'(out_valid), 32'h1);
         chk("mul2_res", 32'(result), 32'h369c);
         chk("mul2_c", 32'(out_flags[2]), 32'h0);

         op(4'he, 16'h0005, 16'h0005); tick();
         in_valid = 1'b0;
         for (int i = 0; i < 4; i++) tick();
         flush = 1'b1; tick();
         flush = 1'b0;
         chk("mul_flush_ready", 32'(in_ready), 32'h1);
         for (int i = 0; i < 20; i++) begin
            chk("mul_flush_valid", 32'(out_valid), 32'h0);
            tick();
         end
      end

      in_valid = 1'b0;
      tick(); tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised execute-stage ALU with an architectural flag register (CCR), valid/ready handshake, stall/flush control and an optional iterative multiplier. Sits in the EX stage between the ID/EX and EX/MEM pipeline registers. Generalises the combinational 16-bit ALU to any `WIDTH`, and adds stateful flags, flag restore and a multi-cycle operation.

## Interface
- `WIDTH`, 16: operand/result width (≥4).
- `SHAMT_W`, 4: shift-amount bits taken from `op2[SHAMT_W-1:0]`; must satisfy 2^SHAMT_W ≥ WIDTH.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous active-high reset.
- `in_valid` in 1: operation present on `func/op1/op2`.
- `in_ready` out 1: ALU accepts an operation this cycle.
- `func` in 4: operation code.
- `op1` in WIDTH: operand 1.
- `op2` in WIDTH: operand 2 / shift amount.
- `stall` in 1: hold all state, accept nothing.
- `flush` in 1: discard the in-flight/accepting operation.
- `flags_wr` in 1: load CCR from `flags_in` (RTI restore).
- `flags_in` in 4: CCR restore value.
- `out_valid` out 1: `result` valid.
- `result` out WIDTH: registered result.
- `out_flags` out 4: CCR; [0]=Z, [1]=N, [2]=C, [3]=V.

## Operation
- Codes: 0000 NOP, 0001 SETC, 0010 CLRC, 0011 MOV op1, 0100 MOV op2, 0101 NOT op1, 0110 INC op1, 0111 DEC op1, 1000 ADD, 1001 SUB (op1−op2), 1010 AND, 1011 OR, 1100 SHL op1, 1101 SHR op1 (logical), 1110 MUL (MUL_EN only), 1111 reserved = NOP.
- Flag updates on commit:
  - ADD/SUB/INC/DEC: Z, N, C, V. SUB/DEC set C=borrow. V is signed overflow.
  - AND/OR/NOT: Z, N only.
  - SHL/SHR: Z, N, and C = last bit shifted out. Shift amount 0: result=op1, C unchanged. Amount ≥ WIDTH: result 0, C=0.
  - SETC/CLRC: C only, result 0.
  - MOV/NOP/reserved: flags unchanged, result per code (NOP → 0).
- Arithmetic is modulo 2^WIDTH; the carry comes from the WIDTH+1-bit sum.
- State machine: IDLE, MUL_BUSY, MUL_DONE.
  - Non-MUL ops stay in IDLE.
  - MUL accept → MUL_BUSY. Shift-add takes WIDTH iterations, then MUL_DONE for one cycle, then IDLE.
  - MUL result = low WIDTH bits of the product. Z and N updated. C=1 when the high half ≠ 0. V unchanged.
- `in_ready` = (state==IDLE) & ~stall & ~rst.
- Priority per cycle: rst > flags_wr > flush > stall > normal.
  - `flags_wr` overrides any same-cycle ALU flag update.
  - `flags_wr` works during stall and flush.

## Timing
- Reset values: `result`=0, `out_valid`=0, `out_flags`=0, state IDLE, multiplier counters 0.
- Single-cycle ops: accepted at edge N; `result`, `out_flags` and `out_valid`=1 are visible after edge N (latency 1). `out_valid` drops the next cycle unless a new op is accepted.
- MUL: accepted at edge N; `out_valid`=1 with the result after edge N+WIDTH+1; `in_ready`=0 from N to N+WIDTH+1.
- `stall`: `result`, `out_valid`, `out_flags`, state and multiplier iteration all frozen.
- `flush`: `out_valid`←0 at the next edge and any MUL is aborted to IDLE. An op presented in the flush cycle is dropped and its flags are not committed. Flags committed earlier are kept.
- `rst` mid-MUL: back to IDLE with reset values at that edge.
- Back-to-back single-cycle ops: one per cycle, with flags chaining correctly (SETC then ADD sees new C only if ADC exists; it does not, so ADD ignores C-in).

## Configuration
- `ALU_MUL_EN` defined: MUL (1110) implemented as above, with the multiplier datapath and the MUL_BUSY/MUL_DONE states present.
- `ALU_MUL_EN` undefined: 1110 behaves as NOP (result 0, flags unchanged, latency 1), and `in_ready` depends only on `stall`/`rst`.

## Test plan
- WIDTH=16, ADD 0x7FFF+0x0001 → result 0x8000, out_flags Z0 N1 C0 V1, out_valid one cycle after accept.
- SUB 0x0001−0x0002 → 0xFFFF, N1 C1 V0 Z0. Then MOV op2 0x1234 → 0x1234 with flags unchanged.
- SHL 0x8001 by 1 → 0x0002, C1. SHR 0x0003 by 0 → 0x0003, C unchanged. SHL by 16 → 0x0000, Z1 C0.
- `flags_wr`=1, `flags_in`=4'b1010 in the same cycle as ADD 1+1 → result 0x0002 and out_flags 4'b1010.
- ALU_MUL_EN: MUL 0x0100×0x0100 → result 0x0000, Z1 C1, out_valid 17 cycles after accept. `in_ready` low throughout; flush at cycle 5 → out_valid never asserts, state IDLE next cycle.
- Stall held 3 cycles after ADD 2+3 → result 5 held, out_valid held. `rst` during stall → all outputs 0 next edge.
